// File: rtl/lut_multiplier_core_if.sv
// Operand/result bundle for lut_multiplier_core: the producer drives a/b/in_valid,
// the multiplier returns result/out_valid.
interface lut_multiplier_core_if #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 32
);
  logic                      in_valid;
  logic signed [IN_W-1:0]    a;
  logic signed [CONST_W-1:0] b;
  logic                      out_valid;
  logic signed [IN_W-1:0]    result;

  modport master (output in_valid, a, b, input  out_valid, result);
  modport slave  (input  in_valid, a, b, output out_valid, result);
endinterface

// File: rtl/lut_multiplier_core.sv
// Multiplier-free signed fixed-point scaler: result = sat((a*b) >>> FRAC), 3-cycle latency.
// Define LUT_MULT_ROUND_EN to round half toward +inf instead of truncating.
module lut_multiplier_core #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 32,
  parameter int FRAC    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  lut_multiplier_core_if.slave  bus
);
  localparam int NIB    = (CONST_W + 3) / 4;
  localparam int BW     = NIB * 4;
  localparam int LUT_W  = IN_W + 4;
  localparam int P_W    = IN_W + CONST_W;
  localparam int STAGES = 3;

  localparam logic signed [P_W-1:0] SMAX = (P_W'(1) <<< (IN_W-1)) - P_W'(1);
  localparam logic signed [P_W-1:0] SMIN = -(P_W'(1) <<< (IN_W-1));

  logic [STAGES-1:0]         vld_pipe;
  logic signed [IN_W-1:0]    a_s1;
  logic signed [CONST_W-1:0] b_s1;
  logic signed [P_W-1:0]     p_s2;
  logic signed [IN_W-1:0]    result_q;

  // S2: a*k table and radix-16 partial products
  logic signed [LUT_W-1:0] ax;
  logic signed [BW-1:0]    b_ext;
  logic signed [LUT_W-1:0] lut [16];
  logic signed [P_W-1:0]   pp  [NIB];
  logic signed [P_W-1:0]   p_sum;

  assign ax    = LUT_W'(a_s1);
  assign b_ext = BW'(b_s1);

  for (genvar k = 0; k < 16; k++) begin : g_lut
    localparam logic [3:0] KB = 4'(k);
    assign lut[k] = (KB[0] ? ax          : '0) + (KB[1] ? (ax <<< 1) : '0)
                  + (KB[2] ? (ax <<< 2)  : '0) + (KB[3] ? (ax <<< 3) : '0);
  end

  for (genvar i = 0; i < NIB; i++) begin : g_pp
    logic [3:0]            d;
    logic signed [P_W-1:0] lut_x;
    logic signed [P_W-1:0] neg_x;
    assign d     = b_ext[4*i +: 4];
    assign lut_x = P_W'(lut[d]);
    if (i == NIB - 1) begin : g_top
      // top digit is signed: a*d - 16a gives a*(d-16) for d in 8..15
      assign neg_x = d[3] ? (P_W'(ax) <<< 4) : {P_W{1'b0}};
    end else begin : g_low
      assign neg_x = {P_W{1'b0}};
    end
    assign pp[i] = (lut_x - neg_x) <<< (4*i);
  end

  always_comb begin
    p_sum = '0;
    for (int i = 0; i < NIB; i++) p_sum = p_sum + pp[i];
  end

  // S3: optional rounding, arithmetic shift, saturation
  logic signed [P_W-1:0]  p_rnd;
  logic signed [P_W-1:0]  p_shr;
  logic signed [IN_W-1:0] sat_val;

`ifdef LUT_MULT_ROUND_EN
  localparam logic signed [P_W-1:0] RND = (FRAC > 0) ? (P_W'(1) <<< (FRAC-1)) : '0;
  assign p_rnd = p_s2 + RND;
`else
  assign p_rnd = p_s2;
`endif

  assign p_shr = p_rnd >>> FRAC;

  always_comb begin
    sat_val = p_shr[IN_W-1:0];
    if (p_shr > SMAX)      sat_val = SMAX[IN_W-1:0];
    else if (p_shr < SMIN) sat_val = SMIN[IN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_s1     <= '0;
      b_s1     <= '0;
      p_s2     <= '0;
      result_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.in_valid};
      a_s1     <= bus.a;
      b_s1     <= bus.b;
      p_s2     <= p_sum;
      // result holds between valid outputs
      if (vld_pipe[STAGES-2]) result_q <= sat_val;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.result    = result_q;
endmodule

// File: tb/tb_lut_multiplier_core.sv
// Directed + randomized bench for lut_multiplier_core against a 64-bit arithmetic model.
module tb_lut_multiplier_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_multiplier_core_if #(.IN_W(32), .CONST_W(32)) bus ();
  lut_multiplier_core #(.IN_W(32), .CONST_W(32), .FRAC(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef LUT_MULT_ROUND_EN
    p = p + 64'sd16384;
`endif
    p = p >>> 15;
    if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    e = model(a, b);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
    @(posedge clk); #1;
    chk("lat_early_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat3_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("dir_result", bus.result, e);
    last_res = e;
    @(posedge clk); #1;
    chk("post_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("hold_result", bus.result, last_res);
  endtask

  task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
    case ($urandom_range(0, 2))
      0: begin a = $urandom; b = $urandom; end
      1: begin a = 32'($signed($urandom) >>> 12); b = 32'($signed($urandom) >>> $urandom_range(12, 20)); end
      default: begin a = $urandom; b = 32'($signed($urandom) >>> $urandom_range(16, 28)); end
    endcase
  endtask

  task automatic stream(input int n, input bit all_valid);
    logic        vin [64];
    logic [31:0] va  [64];
    logic [31:0] vb  [64];
    for (int j = 0; j < n + 2; j++) begin
      if (j < n) begin
        vin[j] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
        rand_ops(va[j], vb[j]);
        bus.in_valid = vin[j]; bus.a = va[j]; bus.b = vb[j];
      end else begin
        bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
      end
      @(posedge clk); #1;
      if (j >= 2) begin
        if (vin[j-2]) last_res = model(va[j-2], vb[j-2]);
        chk("stream_valid", {31'd0, bus.out_valid}, {31'd0, vin[j-2]});
        chk("stream_result", bus.result, last_res);
      end else begin
        chk("stream_fill_valid", {31'd0, bus.out_valid}, 32'd0);
      end
    end
  endtask

  logic [31:0] da [8];
  logic [31:0] db [8];

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b0;

    da = '{32'h0000_8000, 32'h0001_0000, 32'd3,        32'hFFFF_FFFD,
           32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    db = '{32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_4000, 32'h0000_4000,
           32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) run_one(da[i], db[i]);
    run_one(32'h8000_0000, 32'hFFFF_FFFF);

    stream(8, 1'b1);
    stream(40, 1'b0);

    // two ops in flight, then reset together with a fresh input
    run_one(32'h0000_8000, 32'h0000_8000);
    bus.in_valid = 1'b1; rand_ops(da[0], db[0]); bus.a = da[0]; bus.b = db[0];
    @(posedge clk); #1;
    rand_ops(da[1], db[1]); bus.a = da[1]; bus.b = db[1];
    @(posedge clk); #1;
    rst = 1'b1; bus.a = 32'h7FFF_FFFF; bus.b = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    rst = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("after_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("after_rst_result", bus.result, 32'd0);
    end
    last_res = '0;
    run_one(32'hFFFF_0000, 32'h0000_C000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
